// File: rtl/param_sync_fifo_pkg.sv
// Shared constants, count-width helper and status flag bundle for param_sync_fifo.
package fifo_pkg;

    localparam int DEF_DATA_W   = 4;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_AE_LEVEL = 2;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    // One extra bit so an occupancy of exactly DEPTH is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/param_sync_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port; contents not reset.
module fifo_mem #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO with registered status flags and sticky error flags.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int AF_LEVEL = DEPTH - 2,
    parameter  int AE_LEVEL = DEF_AE_LEVEL,
    localparam int CNT_W    = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = CNT_W - 1;

    logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    fifo_status_t      status_q, status_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] mem_rdata;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    // A full FIFO still takes a write when a read frees the head slot that same cycle.
    always_comb begin
        rd_acc = rd_en && !status_q.empty;
        wr_acc = wr_en && (!status_q.full || rd_acc);

        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        status_d.full         = (count_d == CNT_W'(DEPTH));
        status_d.empty        = (count_d == '0);
        status_d.almost_full  = (count_d >= CNT_W'(AF_LEVEL));
        status_d.almost_empty = (count_d <= CNT_W'(AE_LEVEL));

        // New errors take priority over a same-cycle clear.
        overflow_d  = clr_err ? 1'b0 : overflow_q;
        underflow_d = clr_err ? 1'b0 : underflow_q;
        if (wr_en && !wr_acc) begin
            overflow_d = 1'b1;
        end
        if (rd_en && status_q.empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            status_q    <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            status_q    <= status_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    assign rd_data  = mem_rdata;
    assign rd_valid = !status_q.empty;
`else
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    always_comb begin
        rd_data_d  = rd_acc ? mem_rdata : rd_data_q;
        rd_valid_d = rd_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

    assign count        = count_q;
    assign full         = status_q.full;
    assign empty        = status_q.empty;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed self-checking bench for param_sync_fifo at DATA_W=4, DEPTH=8, default levels.
module tb_param_sync_fifo;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_data;
    logic       rd_en;
    logic       clr_err;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int unsigned n_checks;
    int unsigned n_pass;

    param_sync_fifo #(
        .DATA_W (4),
        .DEPTH  (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        wr_data  = '0;
        idle();
        step();
        step();

        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_ae", 32'(almost_empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_af", 32'(almost_full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_unf", 32'(underflow), 0);
        check("rst_rvalid", 32'(rd_valid), 0);
        check("rst_rdata", 32'(rd_data), 0);
        rst = 1'b0;
        step();

`ifdef PARAM_SYNC_FIFO_FWFT_EN
        wr_en = 1'b1; wr_data = 4'hC;
        step();
        idle();
        check("fwft_valid", 32'(rd_valid), 1);
        check("fwft_data", 32'(rd_data), 32'hC);
        check("fwft_count", 32'(count), 1);
        rd_en = 1'b1;
        step();
        idle();
        check("fwft_pop_empty", 32'(empty), 1);
        check("fwft_pop_valid", 32'(rd_valid), 0);
        check("fwft_pop_count", 32'(count), 0);
`else
        // single write / read round trip
        wr_en = 1'b1; wr_data = 4'hA;
        step();
        idle();
        check("t1_count1", 32'(count), 1);
        check("t1_empty0", 32'(empty), 0);
        check("t1_noval", 32'(rd_valid), 0);
        rd_en = 1'b1;
        step();
        idle();
        check("t1_rvalid", 32'(rd_valid), 1);
        check("t1_rdata", 32'(rd_data), 32'hA);
        check("t1_count0", 32'(count), 0);
        check("t1_empty1", 32'(empty), 1);
        step();
        check("t1_rvalid_drop", 32'(rd_valid), 0);
        check("t1_rdata_hold", 32'(rd_data), 32'hA);

        // fill, overflow, drain in order
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 4'(i);
            step();
            check("t2_count", 32'(count), 32'(i + 1));
            check("t2_af", 32'(almost_full), (i + 1 >= 6) ? 1 : 0);
            check("t2_ae", 32'(almost_empty), (i + 1 <= 2) ? 1 : 0);
        end
        check("t2_full", 32'(full), 1);
        wr_en = 1'b1; wr_data = 4'hF;
        step();
        idle();
        check("t2_ovf", 32'(overflow), 1);
        check("t2_count_full", 32'(count), 8);
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            step();
            check("t2_rdata", 32'(rd_data), 32'(i));
            check("t2_rvalid", 32'(rd_valid), 1);
        end
        idle();
        check("t2_empty", 32'(empty), 1);
        clr_err = 1'b1;
        step();
        idle();
        check("t2_ovf_clr", 32'(overflow), 0);

        // full with simultaneous read+write across pointer wrap
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 4'(i);
            step();
        end
        for (int k = 0; k < 20; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 4'(k + 8);
            step();
            check("t3_rdata", 32'(rd_data), 32'(k & 15));
            check("t3_count", 32'(count), 8);
            check("t3_ovf", 32'(overflow), 0);
        end
        idle();
        for (int k = 20; k < 28; k++) begin
            rd_en = 1'b1;
            step();
            check("t3_drain", 32'(rd_data), 32'(k & 15));
        end
        idle();
        check("t3_empty", 32'(empty), 1);

        // underflow, clear, and empty with read+write
        rd_en = 1'b1;
        step();
        idle();
        check("t4_unf", 32'(underflow), 1);
        check("t4_count0", 32'(count), 0);
        check("t4_noval", 32'(rd_valid), 0);
        clr_err = 1'b1;
        step();
        idle();
        check("t4_unf_clr", 32'(underflow), 0);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 4'h3;
        step();
        idle();
        check("t4_count1", 32'(count), 1);
        check("t4_unf_wr", 32'(underflow), 1);
        check("t4_noval2", 32'(rd_valid), 0);
        rd_en = 1'b1;
        step();
        idle();
        check("t4_rdata", 32'(rd_data), 32'h3);
        clr_err = 1'b1; rd_en = 1'b1;
        step();
        idle();
        check("t4_err_wins", 32'(underflow), 1);
        clr_err = 1'b1;
        step();
        idle();
        check("t4_unf_clr2", 32'(underflow), 0);

        // asynchronous reset mid-stream
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1'b1; wr_data = 4'(i);
            step();
        end
        idle();
        check("t5_pre_count", 32'(count), 3);
        rst = 1'b1;
        #1;
        check("t5_count", 32'(count), 0);
        check("t5_empty", 32'(empty), 1);
        check("t5_ae", 32'(almost_empty), 1);
        check("t5_full", 32'(full), 0);
        check("t5_rvalid", 32'(rd_valid), 0);
        step();
        rst = 1'b0;
        step();
        wr_en = 1'b1; wr_data = 4'h5;
        step();
        idle();
        check("t5_count1", 32'(count), 1);
        rd_en = 1'b1;
        step();
        idle();
        check("t5_rdata", 32'(rd_data), 32'h5);
        check("t5_rvalid2", 32'(rd_valid), 1);
        check("t5_empty2", 32'(empty), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
